// File: rtl/ram_clear_port_controller.sv
`default_nettype none
//==============================================================================
//  Module   : ram_clear_port_controller
//  Purpose  : Request controller placed directly in front of one port of
//             simple_dual_port_ram. It presents a valid/ready request
//             interface and a back-pressurable read-response interface to a
//             client. It also runs a hardware sweep that writes CLEAR_VALUE to
//             every RAM index, either after reset or on request. Client traffic
//             is blocked while the sweep runs.
//
//  Ports    : clock, reset (sync, active-low)
//             clear_request                  - starts a sweep when idle
//             req_valid/req_ready/req_write/
//             req_address/req_data           - client request channel
//             resp_valid/resp_ready/resp_data - client read-response channel
//             busy, clear_done               - sweep status
//             ram_writeEnable/ram_writeData/
//             ram_address/ram_readData       - RAM port (1-cycle read latency)
//
//  Revision : 1.0 - initial release
//==============================================================================
module ram_clear_port_controller #(
    parameter int                    DATA_WIDTH     = 32,
    parameter int                    ADDRESS_WIDTH  = 32,
    parameter int                    INDEX_BITS     = 8,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear_request,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_data,
    output logic                     busy,
    output logic                     clear_done,
    output logic                     ram_writeEnable,
    output logic [DATA_WIDTH-1:0]    ram_writeData,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    input  logic [DATA_WIDTH-1:0]    ram_readData
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [INDEX_BITS-1:0] c_cnt_last    = {INDEX_BITS{1'b1}};
    localparam state_t                c_reset_state = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t                     r_state;
    logic [INDEX_BITS-1:0]      r_cnt;
    logic                       r_pending;      // read data is on ram_readData this cycle
    logic                       r_hold_valid;   // stalled read data parked in r_hold_data
    logic [DATA_WIDTH-1:0]      r_hold_data;
    logic                       r_clear_done;
    logic [ADDRESS_WIDTH-1:0]   r_last_addr;
    logic [DATA_WIDTH-1:0]      r_last_wdata;

    logic                       w_accept;
    logic [ADDRESS_WIDTH-1:0]   w_cnt_addr;
    logic                       w_ram_we;
    logic [ADDRESS_WIDTH-1:0]   w_ram_addr;
    logic [DATA_WIDTH-1:0]      w_ram_wdata;

    // Zero-extend the sweep index onto the RAM address bus.
    generate
        if (ADDRESS_WIDTH > INDEX_BITS) begin : g_cnt_pad
            assign w_cnt_addr = {{(ADDRESS_WIDTH-INDEX_BITS){1'b0}}, r_cnt};
        end else begin : g_cnt_trunc
            assign w_cnt_addr = r_cnt[ADDRESS_WIDTH-1:0];
        end
    endgenerate

    // A new request may issue when idle and no response would be left without
    // a place to live: the hold register must be empty, and any response now
    // on ram_readData must be consumed this cycle.
    assign req_ready  = (r_state == ST_IDLE) & ~r_hold_valid & ~(r_pending & ~resp_ready);
    assign w_accept   = req_valid & req_ready;

    assign resp_valid = r_pending | r_hold_valid;
    assign resp_data  = r_hold_valid ? r_hold_data : ram_readData;
    assign busy       = (r_state == ST_CLEAR);
    assign clear_done = r_clear_done;

    // RAM port drive. The sweep owns the port. Otherwise an accepted request
    // drives it. When the port is unused, address and data keep their last
    // values so the bus does not toggle needlessly.
    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_addr  = r_last_addr;
        w_ram_wdata = r_last_wdata;
        if (r_state == ST_CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_addr  = w_cnt_addr;
            w_ram_wdata = CLEAR_VALUE;
        end else if (w_accept) begin
            w_ram_we    = req_write;
            w_ram_addr  = req_address;
            w_ram_wdata = req_data;
        end
    end

    assign ram_writeEnable = w_ram_we;
    assign ram_address     = w_ram_addr;
    assign ram_writeData   = w_ram_wdata;

    // Control state: sweep FSM, response tracking and the done pulse.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= c_reset_state;
            r_cnt        <= '0;
            r_pending    <= 1'b0;
            r_hold_valid <= 1'b0;
            r_clear_done <= 1'b0;
        end else begin
            r_clear_done <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_cnt <= r_cnt + 1'b1;      // wraps to 0 after the last index
                if (r_cnt == c_cnt_last) begin
                    r_state      <= ST_IDLE;
                    r_clear_done <= 1'b1;
                end
            end else if (clear_request) begin
                r_state <= ST_CLEAR;
                r_cnt   <= '0;
            end

            r_pending <= w_accept & ~req_write;

            // Park a response the client did not take, and release it once it
            // is taken. Both flags are never set together, because req_ready
            // blocks new reads while the hold register is full.
            if (r_pending && !resp_ready) begin
                r_hold_valid <= 1'b1;
            end else if (r_hold_valid && resp_ready) begin
                r_hold_valid <= 1'b0;
            end
        end
    end

    // Datapath registers. These need no reset because their contents are
    // only observed behind a control flag, or as the idle bus value.
    always_ff @(posedge clock) begin
        if (r_pending && !resp_ready) begin
            r_hold_data <= ram_readData;
        end
        r_last_addr  <= w_ram_addr;
        r_last_wdata <= w_ram_wdata;
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_clear_port_controller.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
//  Module   : tb_ram_clear_port_controller
//  Purpose  : Self-checking bench for ram_clear_port_controller. It uses a
//             behavioural RAM (registered read, 16 words). A reference model
//             tracks sweep progress, memory contents and the single
//             outstanding response. The bench combines table vectors,
//             hand-written corner sequences and random traffic.
//  Revision : 1.0 - initial release
//==============================================================================
module tb_ram_clear_port_controller;

    localparam int          DW    = 32;
    localparam int          AW    = 32;
    localparam int          IB    = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] CV    = 32'hDEADBEEF;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          clear_request = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic          resp_ready = 1'b0;
    logic [AW-1:0] req_address = '0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready, resp_valid, busy, clear_done, ram_writeEnable;
    logic [DW-1:0] resp_data, ram_writeData, ram_readData;
    logic [AW-1:0] ram_address;

    ram_clear_port_controller #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .INDEX_BITS(IB),
        .CLEAR_VALUE(CV), .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clock(clock), .reset(reset), .clear_request(clear_request),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .busy(busy), .clear_done(clear_done),
        .ram_writeEnable(ram_writeEnable), .ram_writeData(ram_writeData),
        .ram_address(ram_address), .ram_readData(ram_readData)
    );

    always #5 clock = ~clock;

    // Behavioural RAM port: registered read that returns the old data.
    logic [DW-1:0] ram_mem [DEPTH];
    always @(posedge clock) begin
        if (ram_writeEnable) ram_mem[ram_address[IB-1:0]] <= ram_writeData;
        ram_readData <= ram_mem[ram_address[IB-1:0]];
    end

    // Reference model state.
    int          m_left;        // sweep writes still to do
    bit          m_have;        // a response is visible to the client
    bit          m_stalled;     // that response was already refused once
    bit          m_cd;
    bit          m_last_ok;
    logic [31:0] m_resp, m_last_addr, m_last_wd;
    logic [31:0] m_mem [DEPTH];

    int n_checks = 0;
    int n_fail   = 0;

    logic        s_busy, s_cd, s_ready, s_valid;
    logic [31:0] s_data, s_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, advance the model.
    task automatic step(input bit rst_n, input bit cr, input bit rv, input bit rw,
                        input logic [31:0] ra, input logic [31:0] rd, input bit rr);
        bit          busy_e, ready_e, acc, we_e;
        logic [31:0] addr_e, wd_e, rdval;
        reset = rst_n; clear_request = cr; req_valid = rv; req_write = rw;
        req_address = ra; req_data = rd; resp_ready = rr;
        #4;
        busy_e  = (m_left > 0);
        ready_e = !busy_e && !(m_have && m_stalled) && !(m_have && !rr);
        acc     = rv && ready_e;
        we_e    = busy_e ? 1'b1 : (acc ? rw : 1'b0);
        addr_e  = busy_e ? 32'(DEPTH - m_left) : (acc ? ra : m_last_addr);
        wd_e    = busy_e ? CV : (acc ? rd : m_last_wd);
        s_busy = busy; s_cd = clear_done; s_ready = req_ready;
        s_valid = resp_valid; s_data = resp_data; s_addr = ram_address;
        chk("busy", busy, busy_e);
        chk("req_ready", req_ready, ready_e);
        chk("resp_valid", resp_valid, m_have);
        if (m_have) chk("resp_data", resp_data, m_resp);
        chk("clear_done", clear_done, m_cd);
        chk("ram_we", ram_writeEnable, we_e);
        if (we_e || m_last_ok) begin
            chk("ram_addr", ram_address, addr_e);
            chk("ram_wdata", ram_writeData, wd_e);
        end
        @(posedge clock);
        rdval = m_mem[ra[IB-1:0]];
        if (busy_e) m_mem[DEPTH - m_left] = CV;
        else if (acc && rw) m_mem[ra[IB-1:0]] = rd;
        m_last_addr = addr_e; m_last_wd = wd_e; m_last_ok = 1'b1;
        if (!rst_n) begin
            m_left = DEPTH; m_have = 0; m_stalled = 0; m_cd = 0;
        end else begin
            m_cd = (m_left == 1);
            if (m_left > 0) m_left--;
            else if (cr) m_left = DEPTH;
            if (acc && !rw) begin
                m_have = 1; m_stalled = 0; m_resp = rdval;
            end else if (m_have && !rr) begin
                m_stalled = 1;
            end else begin
                m_have = 0; m_stalled = 0;
            end
        end
        #1;
    endtask

    task automatic idle(input bit rr, input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 32'd0, 32'd0, rr);
    endtask

    typedef struct {
        bit          rv;
        bit          rw;
        logic [31:0] a;
        logic [31:0] d;
        bit          rr;
        bit          e_ready;
        bit          e_valid;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl [15];
    int   cnt_busy, cnt_cd;

    initial begin
        // Write/read, write-no-response, and stalled back-to-back reads.
        tbl[0]  = '{1'b1, 1'b1, 32'd3, 32'h12345678, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'd3, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'd7, 32'h0,        1'b1, 1'b1, 1'b1, 32'h12345678};
        tbl[3]  = '{1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'd1, 32'hA1A1A1A1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'd2, 32'hA2A2A2A2, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 1'b0, 32'd1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'd2, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA1A1A1A1};
        tbl[9]  = '{1'b1, 1'b0, 32'd2, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA1A1A1A1};
        tbl[10] = '{1'b1, 1'b0, 32'd2, 32'h0,        1'b0, 1'b0, 1'b1, 32'hA1A1A1A1};
        tbl[11] = '{1'b1, 1'b0, 32'd2, 32'h0,        1'b1, 1'b0, 1'b1, 32'hA1A1A1A1};
        tbl[12] = '{1'b1, 1'b0, 32'd2, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hA2A2A2A2};
        tbl[14] = '{1'b0, 1'b0, 32'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h0};

        for (int i = 0; i < DEPTH; i++) begin
            ram_mem[i] = 32'h11111111 * i;
            m_mem[i]   = 32'h11111111 * i;
        end

        // First edge under reset brings the DUT to a known state.
        @(posedge clock); #1;
        m_left = DEPTH; m_have = 0; m_stalled = 0; m_cd = 0; m_last_ok = 0;
        m_resp = '0; m_last_addr = '0; m_last_wd = '0;
        step(0, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("reset_busy", s_busy, 1'b1);
        chk("reset_ready", s_ready, 1'b0);
        chk("reset_valid", s_valid, 1'b0);

        // Sweep after reset release.
        cnt_cd = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 0, 0, 32'd0, 32'd0, 1);
            if (i < DEPTH) chk("sweep_addr", s_addr, 32'(i));
            chk("sweep_busy", s_busy, (i < DEPTH) ? 1'b1 : 1'b0);
            cnt_cd += int'(s_cd);
        end
        chk("sweep_done_pulses", cnt_cd, 32'd1);

        for (int i = 0; i < 15; i++) begin
            step(1, 0, tbl[i].rv, tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].rr);
            chk("tbl_ready", s_ready, tbl[i].e_ready);
            chk("tbl_valid", s_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk("tbl_data", s_data, tbl[i].e_data);
        end

        // clear_request during a sweep must not restart or extend it.
        cnt_busy = 0; cnt_cd = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, (i == 0 || i == 5), 0, 0, 32'd0, 32'd0, 1);
            cnt_busy += int'(s_busy);
            cnt_cd   += int'(s_cd);
        end
        chk("midsweep_busy_cycles", cnt_busy, 32'd16);
        chk("midsweep_done_pulses", cnt_cd, 32'd1);

        // Read in the same cycle as clear_request returns pre-sweep data.
        step(1, 0, 1, 1, 32'd5, 32'h55AA55AA, 1);
        step(1, 1, 1, 0, 32'd5, 32'd0, 0);
        chk("race_read_ready", s_ready, 1'b1);
        idle(0, 16);
        step(1, 0, 0, 0, 32'd0, 32'd0, 0);
        chk("race_held_valid", s_valid, 1'b1);
        chk("race_held_data", s_data, 32'h55AA55AA);
        chk("race_idle_after", s_busy, 1'b0);
        step(1, 0, 0, 0, 32'd0, 32'd0, 1);
        step(1, 0, 1, 0, 32'd5, 32'd0, 1);
        chk("race_consumed", s_valid, 1'b0);
        step(1, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("post_sweep_read", s_data, 32'hDEADBEEF);

        // Reset during a sweep at cnt=9.
        step(1, 1, 0, 0, 32'd0, 32'd0, 1);
        idle(1, 9);
        step(0, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("midreset_addr", s_addr, 32'd9);
        step(1, 0, 0, 0, 32'd0, 32'd0, 1);
        chk("midreset_busy", s_busy, 1'b1);
        chk("midreset_ready", s_ready, 1'b0);
        chk("midreset_restart", s_addr, 32'd0);
        idle(1, 17);

        // Reset during a stalled response discards it.
        step(1, 0, 1, 0, 32'd2, 32'd0, 0);
        step(1, 0, 0, 0, 32'd0, 32'd0, 0);
        step(1, 0, 0, 0, 32'd0, 32'd0, 0);
        chk("stall_before_reset", s_valid, 1'b1);
        step(0, 0, 0, 0, 32'd0, 32'd0, 0);
        step(1, 0, 0, 0, 32'd0, 32'd0, 0);
        chk("stall_reset_valid", s_valid, 1'b0);
        chk("stall_reset_ready", s_ready, 1'b0);
        idle(1, 17);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 149) != 0), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                 32'($urandom_range(0, DEPTH-1)), $urandom,
                 ($urandom_range(0, 9) < 6));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_clear_port_controller.md
Name: ram_clear_port_controller

Overview:
- Single-port request controller that sits directly upstream of one port of simple_dual_port_ram and drives that port's writeEnable, writeData and address lines.
- Presents a valid/ready request interface and a read-response interface to the client, and hides the RAM's 1-cycle read latency behind a 1-entry hold register so responses can be back-pressured.
- Runs a hardware sweep that writes CLEAR_VALUE to every RAM index after reset, or on request, and blocks client traffic while the sweep runs.

Parameters:
- DATA_WIDTH, 32: RAM word width.
- ADDRESS_WIDTH, 32: RAM address port width.
- INDEX_BITS, 8: log2 of the RAM depth; the sweep covers indices 0 to 2^INDEX_BITS-1.
- CLEAR_VALUE, 0: DATA_WIDTH-bit word written at every index during a sweep.
- CLEAR_ON_RESET, 1: 1 = a sweep starts automatically when reset is released; 0 = the block comes out of reset in IDLE.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- clear_request  in  1  single-cycle pulse; starts a sweep when sampled in IDLE.
- req_valid  in  1  client request valid.
- req_ready  out  1  controller can accept a request this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  ADDRESS_WIDTH  request address.
- req_data  in  DATA_WIDTH  write data.
- resp_valid  out  1  read data valid.
- resp_ready  in  1  client consumes the response this cycle.
- resp_data  out  DATA_WIDTH  read data.
- busy  out  1  high while a sweep is in progress.
- clear_done  out  1  one-cycle pulse in the cycle after the last sweep write.
- ram_writeEnable  out  1  to the RAM port's writeEnable.
- ram_writeData  out  DATA_WIDTH  to the RAM port's writeData.
- ram_address  out  ADDRESS_WIDTH  to the RAM port's address.
- ram_readData  in  DATA_WIDTH  from the RAM port's readData (registered, 1-cycle latency).

Behaviour:
- FSM states: CLEAR and IDLE, with an INDEX_BITS-wide sweep counter cnt.
- Reset (reset==0 at a clock edge):
  - state = CLEAR with cnt = 0 if CLEAR_ON_RESET, otherwise IDLE.
  - pending = 0, hold_valid = 0, clear_done = 0.
  - All outputs evaluate from these register values: busy = CLEAR_ON_RESET, req_ready = 0, resp_valid = 0.
  - Reset asserted mid-sweep or mid-response discards all state; no response is delivered afterwards.
- CLEAR state, every cycle:
  - ram_writeEnable = 1, ram_address = cnt zero-extended to ADDRESS_WIDTH, ram_writeData = CLEAR_VALUE; cnt increments.
  - When cnt == 2^INDEX_BITS-1: go to IDLE and pulse clear_done in the next cycle.
  - A sweep takes exactly 2^INDEX_BITS cycles. cnt wraps to 0.
  - clear_request is ignored while in CLEAR (no restart, no extension).
- IDLE state:
  - clear_request==1 moves to CLEAR next cycle with cnt = 0.
  - If a request is accepted in the same cycle, it still executes.
- req_ready = (state==IDLE) & ~hold_valid & ~(pending & ~resp_ready). Accept = req_valid & req_ready.
- On accept, ram_address = req_address (passed unmodified). ram_writeEnable = req_write, ram_writeData = req_data.
- When there is no accept and the state is not CLEAR: ram_writeEnable = 0, and ram_address and ram_writeData hold their last values.
- Writes produce no response.
- Reads: pending is set in the cycle after an accepted read.
  - While pending: resp_valid = 1 and resp_data = ram_readData.
  - If resp_ready==0 while pending, ram_readData is captured into the hold register; hold_valid = 1 and pending clears.
  - While hold_valid: resp_valid = 1 and resp_data = hold register; hold_valid clears on resp_ready.
- Back-to-back reads with resp_ready held high: throughput is 1 read per cycle; latency is 1 cycle from accept to resp_valid.
- A read accepted in the cycle that clear_request arrives returns the pre-sweep data at that address.
- resp_valid never drops without resp_ready. Responses are delivered in request order, with at most one outstanding.

Test Plan:
- Reset release with CLEAR_ON_RESET=1, INDEX_BITS=4, CLEAR_VALUE=0xDEADBEEF -> busy high for 16 cycles; ram_address steps 0..15; clear_done pulses once; then read of index 7 returns 0xDEADBEEF.
- In IDLE: write 0x12345678 to address 3, then read address 3 with resp_ready=1 -> resp_valid exactly 1 cycle after accept with 0x12345678; writes give no resp_valid.
- Reads of addresses 1 and 2 back-to-back with resp_ready=0 for 3 cycles -> the first response is held stable, req_ready=0 during the stall, the second read is accepted only after the first response is consumed; order is preserved.
- clear_request pulsed mid-sweep (cycle 5 of 16) -> sweep still finishes at cycle 16 with a single clear_done; no restart.
- Read accepted in the same cycle as clear_request, with resp_ready=0 -> response returns the pre-sweep value, is held through the sweep, and is delivered when resp_ready rises.
- reset driven low during a sweep at cnt=9 and during a stalled response -> the next edge gives resp_valid=0, req_ready=0, and the sweep restarts from 0.
